// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
package dsp_mac_sequencer_pkg;

   // Operand, product, accumulator and OPMODE widths of the slice.
   localparam int A_W   = 18;
   localparam int M_W   = 36;
   localparam int P_W   = 48;
   localparam int OPM_W = 8;

   // OPMODE codes: pre-adder off, add, carry 0.
   // FIRST  : X=M, Z=0 (starts a new sum and drops whatever P held)
   // ACC    : X=M, Z=P (adds the product to the running sum)
   // IDLE_OP: X=0, Z=0
   localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
   localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
   localparam logic [OPM_W-1:0] OPM_IDLE  = 8'h00;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream, result stream and DSP slice signals of the sequencer.
interface dsp_mac_sequencer_if;
   import dsp_mac_sequencer_pkg::*;

   logic             inValid;
   logic             inReady;
   logic [A_W-1:0]   inA;
   logic [A_W-1:0]   inB;
   logic             outValid;
   logic             outReady;
   logic [P_W-1:0]   outP;
   logic [A_W-1:0]   dspA;
   logic [A_W-1:0]   dspB;
   logic [OPM_W-1:0] dspOpmode;
   logic [P_W-1:0]   dspP;

   // Sequencer side.
   modport master (
      input  inValid, inA, inB, outReady, dspP,
      output inReady, outValid, outP, dspA, dspB, dspOpmode
   );

   // Source, sink and slice side.
   modport slave (
      output inValid, inA, inB, outReady, dspP,
      input  inReady, outValid, outP, dspA, dspB, dspOpmode
   );

endinterface

// File: rtl/dsp_mac_sequencer_tag_delay_line.sv
// Fixed-depth OPMODE shift register that lines the OPMODE tag up with the
// slice's operand pipeline; a synchronous clear flushes it to IDLE_OP.
module tag_delay_line
   import dsp_mac_sequencer_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [OPM_W-1:0] i_tag,
   output logic [OPM_W-1:0] o_tag
);

   logic [OPM_W-1:0] r_stages [DEPTH];

   // Shift one stage per edge; clear returns every stage to IDLE_OP (all zero).
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_stages <= '{default: '0};
      end else begin
         r_stages[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_stages[i] <= r_stages[i-1];
         end
      end
   end

   assign o_tag = r_stages[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice through an N_TAPS multiply-accumulate per vector
// and returns the slice's final P value on a valid/ready result port.
module dsp_mac_sequencer
   import dsp_mac_sequencer_pkg::*;
#(
   parameter int N_TAPS  = 8,
   parameter int OPM_DLY = 1,
   parameter int RES_DLY = 3
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   dsp_mac_sequencer_if.master io_bus
);

   localparam int TAP_W = $clog2(N_TAPS + 1);
   localparam int DRN_W = $clog2(RES_DLY + 2);

   state_e             r_state,    w_state;
   logic [TAP_W-1:0]   r_tapCnt,   w_tapCnt;
   logic [DRN_W-1:0]   r_drainCnt, w_drainCnt;
   logic [A_W-1:0]     r_dspA,     w_dspA;
   logic [A_W-1:0]     r_dspB,     w_dspB;
   logic [OPM_W-1:0]   r_tag,      w_tag;
   logic               r_inReady,  w_inReady;
   logic               r_outValid, w_outValid;
   logic [P_W-1:0]     r_outP,     w_outP;
   logic [OPM_W-1:0]   w_opmode;
   logic               w_inFire;
   logic               w_outFire;

   assign w_inFire  = io_bus.inValid && r_inReady;
   assign w_outFire = r_outValid && io_bus.outReady;

   // Next-state and next-output logic; operands default to zero so that any
   // cycle without an accepted tap adds nothing to the sum.
   always_comb begin
      w_state    = r_state;
      w_tapCnt   = r_tapCnt;
      w_drainCnt = r_drainCnt;
      w_dspA     = '0;
      w_dspB     = '0;
      w_tag      = OPM_IDLE;
      w_outValid = r_outValid;
      w_outP     = r_outP;
      case (r_state)
         S_IDLE: begin
            if (w_inFire) begin
               w_dspA   = io_bus.inA;
               w_dspB   = io_bus.inB;
               w_tag    = OPM_FIRST;
               w_tapCnt = TAP_W'(1);
               w_state  = S_ACCUM;
            end
         end
         S_ACCUM: begin
            w_tag = OPM_ACC;
            if (w_inFire) begin
               w_dspA   = io_bus.inA;
               w_dspB   = io_bus.inB;
               w_tapCnt = r_tapCnt + TAP_W'(1);
               if (r_tapCnt == TAP_W'(N_TAPS - 1)) begin
                  w_drainCnt = DRN_W'(RES_DLY + 1);
                  w_state    = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            w_drainCnt = r_drainCnt - DRN_W'(1);
            if (r_drainCnt == DRN_W'(1)) begin
               w_outP     = io_bus.dspP;
               w_outValid = 1'b1;
               w_state    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_outFire) begin
               w_outValid = 1'b0;
               w_tapCnt   = '0;
               w_state    = S_IDLE;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
      w_inReady = (w_state == S_IDLE) || (w_state == S_ACCUM);
   end

   // State and registered outputs; reset drops any partial vector.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state    <= S_IDLE;
         r_tapCnt   <= '0;
         r_drainCnt <= '0;
         r_dspA     <= '0;
         r_dspB     <= '0;
         r_tag      <= OPM_IDLE;
         r_inReady  <= 1'b0;
         r_outValid <= 1'b0;
         r_outP     <= '0;
      end else begin
         r_state    <= w_state;
         r_tapCnt   <= w_tapCnt;
         r_drainCnt <= w_drainCnt;
         r_dspA     <= w_dspA;
         r_dspB     <= w_dspB;
         r_tag      <= w_tag;
         r_inReady  <= w_inReady;
         r_outValid <= w_outValid;
         r_outP     <= w_outP;
      end
   end

   tag_delay_line #(
      .DEPTH (OPM_DLY)
   ) u_tagDelay (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_tag  (r_tag),
      .o_tag  (w_opmode)
   );

   assign io_bus.inReady   = r_inReady;
   assign io_bus.outValid  = r_outValid;
   assign io_bus.outP      = r_outP;
   assign io_bus.dspA      = r_dspA;
   assign io_bus.dspB      = r_dspB;
   assign io_bus.dspOpmode = w_opmode;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: drives it against a behavioural DSP48A1 slice
// (A1/B1, MREG, OPMODEREG, PREG) and compares results with a sum-of-products model.
module tb_dsp_mac_sequencer;
   import dsp_mac_sequencer_pkg::*;

   localparam int N       = 4;
   localparam int RES_LAT = 4;

   logic clk = 1'b0;
   logic rstn;
   int   testCount = 0;
   int   failCount = 0;
   time  tLast;

   logic [A_W-1:0] vecA   [N];
   logic [A_W-1:0] vecB   [N];
   int             vecGap [N];

   dsp_mac_sequencer_if bus ();

   dsp_mac_sequencer #(
      .N_TAPS  (N),
      .OPM_DLY (1),
      .RES_DLY (3)
   ) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .io_bus (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // DSP slice with default registers; never reset, so only FIRST clears Z.
   logic [A_W-1:0]   sliceA1  = '0;
   logic [A_W-1:0]   sliceB1  = '0;
   logic [M_W-1:0]   sliceM   = '0;
   logic [OPM_W-1:0] sliceOpm = '0;
   logic [P_W-1:0]   sliceP   = '0;

   // Slice pipeline: operand regs, multiplier reg, OPMODE reg, then P.
   always @(posedge clk) begin
      sliceA1  <= bus.dspA;
      sliceB1  <= bus.dspB;
      sliceM   <= M_W'(sliceA1) * M_W'(sliceB1);
      sliceOpm <= bus.dspOpmode;
      sliceP   <= ((sliceOpm[1:0] == 2'b01) ? P_W'(sliceM) : '0)
                + ((sliceOpm[3:2] == 2'b10) ? sliceP : '0);
   end

   assign bus.dspP = sliceP;

   // Safety net in case the bench stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [P_W-1:0] obs,
                              input logic [P_W-1:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected result: plain sum of products of the first n pairs, mod 2^48.
   function automatic logic [P_W-1:0] modelSum(input int n);
      logic [P_W-1:0] s;
      s = '0;
      for (int i = 0; i < n; i++) s = s + P_W'(vecA[i]) * P_W'(vecB[i]);
      return s;
   endfunction

   // Present n taps from vecA/vecB, inserting vecGap[i] idle cycles after tap i.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         int guard;
         bus.inValid = 1'b1;
         bus.inA     = vecA[i];
         bus.inB     = vecB[i];
         guard = 0;
         while (!bus.inReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 20) checkOutput("inReadyTimeout", P_W'(bus.inReady), P_W'(1));
         @(posedge clk);
         tLast = $time;
         #1;
         bus.inValid = 1'b0;
         for (int g = 0; g < vecGap[i]; g++) begin
            @(posedge clk); #1;
            checkOutput("bubbleDspA", P_W'(bus.dspA), '0);
            checkOutput("bubbleDspB", P_W'(bus.dspB), '0);
         end
      end
   endtask

   // Wait for the result, hold it off for holdCycles, then take it; with
   // preload the next vector's first tap is already valid at the handshake.
   task automatic waitResult(input logic [P_W-1:0] exp, input int holdCycles,
                             input bit preload);
      int  guard;
      time tRise;
      guard = 0;
      do begin
         @(posedge clk); #1;
         guard++;
      end while (!bus.outValid && guard < 30);
      checkOutput("resultValid", P_W'(bus.outValid), P_W'(1));
      tRise = $time - 1;
      checkOutput("latency", P_W'((tRise - tLast) / 10), P_W'(RES_LAT));
      checkOutput("outP", bus.outP, exp);
      for (int h = 0; h < holdCycles; h++) begin
         @(posedge clk); #1;
         checkOutput("holdValid", P_W'(bus.outValid), P_W'(1));
         checkOutput("holdOutP", bus.outP, exp);
         checkOutput("holdInReady", P_W'(bus.inReady), '0);
      end
      bus.outReady = 1'b1;
      if (preload) begin
         bus.inValid = 1'b1;
         bus.inA     = vecA[0];
         bus.inB     = vecB[0];
      end
      @(posedge clk); #1;
      bus.outReady = 1'b0;
      checkOutput("takenValid", P_W'(bus.outValid), '0);
      checkOutput("takenInReady", P_W'(bus.inReady), P_W'(1));
      checkOutput("noAcceptInHold", P_W'(bus.dspA), '0);
   endtask

   task automatic setPairs(input logic [A_W-1:0] a0, b0, a1, b1, a2, b2, a3, b3);
      vecA[0] = a0; vecB[0] = b0; vecA[1] = a1; vecB[1] = b1;
      vecA[2] = a2; vecB[2] = b2; vecA[3] = a3; vecB[3] = b3;
      for (int i = 0; i < N; i++) vecGap[i] = 0;
   endtask

   initial begin
      logic [P_W-1:0] exp;
      rstn         = 1'b0;
      bus.inValid  = 1'b0;
      bus.inA      = '0;
      bus.inB      = '0;
      bus.outReady = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstInReady", P_W'(bus.inReady), '0);
      checkOutput("rstOutValid", P_W'(bus.outValid), '0);
      checkOutput("rstOutP", bus.outP, '0);
      checkOutput("rstDspA", P_W'(bus.dspA), '0);
      checkOutput("rstOpmode", P_W'(bus.dspOpmode), '0);
      rstn = 1'b1;
      @(posedge clk); #1;
      checkOutput("relInReady", P_W'(bus.inReady), P_W'(1));

      // Back-to-back taps.
      setPairs(1, 2, 3, 4, 5, 6, 7, 8);
      applyStimulus(N);
      waitResult(48'd100, 0, 1'b0);

      // Two bubbles after tap 2.
      setPairs(1, 2, 3, 4, 5, 6, 7, 8);
      vecGap[1] = 2;
      applyStimulus(N);
      waitResult(48'd100, 0, 1'b0);

      // Back-pressure for 5 cycles; next vector arrives during the handshake.
      setPairs(1, 2, 3, 4, 5, 6, 7, 8);
      applyStimulus(N);
      setPairs(1, 1, 1, 1, 1, 1, 1, 1);
      waitResult(48'd100, 5, 1'b1);
      applyStimulus(N);
      waitResult(48'd4, 0, 1'b0);

      // Largest operands.
      setPairs(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF,
               18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
      applyStimulus(N);
      waitResult(48'h3FFFE00004, 0, 1'b0);

      // Reset after tap 2 aborts the vector.
      setPairs(9, 9, 9, 9, 9, 9, 9, 9);
      applyStimulus(2);
      rstn = 1'b0;
      @(posedge clk); #1;
      checkOutput("midRstInReady", P_W'(bus.inReady), '0);
      checkOutput("midRstOpmode", P_W'(bus.dspOpmode), '0);
      rstn = 1'b1;
      @(posedge clk); #1;
      checkOutput("midRelOutValid", P_W'(bus.outValid), '0);
      checkOutput("midRelInReady", P_W'(bus.inReady), P_W'(1));
      setPairs(2, 3, 2, 3, 2, 3, 2, 3);
      applyStimulus(N);
      waitResult(48'd24, 0, 1'b0);

      // Random vectors with random bubbles and back-pressure.
      for (int i = 0; i < N; i++) begin
         vecA[i]   = A_W'($urandom);
         vecB[i]   = A_W'($urandom);
         vecGap[i] = (i < N - 1) ? int'($urandom_range(0, 2)) : 0;
      end
      for (int k = 0; k < 6; k++) begin
         applyStimulus(N);
         exp = modelSum(N);
         for (int i = 0; i < N; i++) begin
            vecA[i]   = A_W'($urandom);
            vecB[i]   = A_W'($urandom);
            vecGap[i] = (i < N - 1) ? int'($urandom_range(0, 2)) : 0;
         end
         waitResult(exp, int'($urandom_range(0, 3)), k < 5);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
